// File: rtl/imm_extend_stage.sv
// -----------------------------------------------------------------------------
// imm_extend_stage
//
// Registered immediate extender sitting between the IF/ID and ID/EX registers.
// Decodes instr[31:7] with an immediate-type select into an XLEN-wide
// immediate, tags it with a sideband value (normally the PC) and presents it
// through a 2-entry skid buffer with a valid/ready handshake and a flush.
//
// Optional feature macro: IMM_EXT_ZICSR_EN
//   defined   : select 3'b111 is the CSR zimm type (zero-extended instr[19:15])
//   undefined : select 3'b111 yields imm=0 and out_illegal=1
//
// Parameters:
//   XLEN  - immediate width, 32 or 64
//   TAG_W - sideband tag width
//
// Ports:
//   clk, rst_n    - clock (rising edge), asynchronous active-low reset
//   flush         - synchronous flush, discards every held entry
//   in_valid      - upstream presents an instruction
//   in_ready      - registered; stage can take an instruction this cycle
//   in_instr      - instruction bits [31:7]
//   in_imm_src    - immediate type select
//   in_tag        - sideband tag
//   out_valid     - out_imm/out_tag/out_illegal hold a valid entry
//   out_ready     - downstream accepts the presented entry
//   out_imm       - extended immediate
//   out_tag       - tag of the presented entry
//   out_illegal   - the entry's select code was unsupported
// -----------------------------------------------------------------------------
module imm_extend_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  // Occupancy of the buffer: EMPTY, main only, main plus skid.
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state, next_state;
  entry_t main_q, skid_q, in_entry;
  logic   in_ready_q;
  logic   accept, pop;
  logic   load_main, load_skid, skid_to_main;

  // ---------------------------------------------------------------------------
  // Extension. in_instr[k-7] holds instruction bit k, so instr[31] is
  // in_instr[24], instr[20] is in_instr[13], instr[7] is in_instr[0].
  // Signed fields are cast to XLEN, which sign-extends a $signed operand and
  // zero-extends an unsigned one.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    in_entry         = '0;
    in_entry.tag     = in_tag;
    case (in_imm_src)
      3'b000: in_entry.imm = XLEN'($signed({in_instr[24:5], 12'b0}));
      3'b001: in_entry.imm = XLEN'($signed({in_instr[24], in_instr[12:5],
                                            in_instr[13], in_instr[23:14],
                                            1'b0}));
      3'b010: in_entry.imm = XLEN'($signed({in_instr[24:18], in_instr[4:0]}));
      3'b011: in_entry.imm = XLEN'($signed({in_instr[24], in_instr[0],
                                            in_instr[23:18], in_instr[4:1],
                                            1'b0}));
      3'b100: in_entry.imm = XLEN'($signed(in_instr[24:13]));
      // Shift amount: 6 bits on RV64, 5 bits on RV32.
      3'b101: in_entry.imm = (XLEN == 64) ? XLEN'(in_instr[18:13])
                                          : XLEN'(in_instr[17:13]);
      3'b110: in_entry.imm = XLEN'(in_instr[24:13]);
      default: begin
`ifdef IMM_EXT_ZICSR_EN
        in_entry.imm     = XLEN'(in_instr[12:8]);
`else
        in_entry.imm     = '0;
        in_entry.illegal = 1'b1;
`endif
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Skid-buffer control. in_ready comes straight from a flop, so upstream
  // never sees a combinational path from out_ready.
  // ---------------------------------------------------------------------------
  assign accept = in_valid & in_ready_q;
  assign pop    = (state != EMPTY) & out_ready;

  always_comb begin
    next_state   = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (flush) begin
      // Flush wins over a same-cycle accept and pop.
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          next_state = ONE;
          load_main  = 1'b1;
        end
        ONE: begin
          if (accept && !pop) begin
            next_state = TWO;
            load_skid  = 1'b1;
          end else if (accept && pop) begin
            load_main  = 1'b1;
          end else if (pop) begin
            next_state = EMPTY;
          end
        end
        TWO: if (pop) begin
          // in_ready is low here, so nothing new arrives this cycle.
          next_state   = ONE;
          skid_to_main = 1'b1;
        end
        default: next_state = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
    end else begin
      state      <= next_state;
      in_ready_q <= (next_state != TWO);
      if (load_main) begin
        main_q <= in_entry;
      end else if (skid_to_main) begin
        main_q <= skid_q;
      end
    end
  end

  // NOTE: the skid payload has no reset; it is only ever read after state says
  // it was written, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_q <= in_entry;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state != EMPTY);
  assign out_imm     = main_q.imm;
  assign out_tag     = main_q.tag;
  assign out_illegal = main_q.illegal;

endmodule

// File: doc/imm_extend_stage.md
Name: imm_extend_stage

Overview:
- Registered, parametrised successor to the decode-stage immediate extender.
- Takes instr[31:7] plus an immediate-source select and produces an XLEN-wide extended immediate, tagged with the instruction.
- Output goes through a 2-entry skid buffer with valid/ready handshake and a flush input.
- Sits between the IF/ID register and the ID/EX register; supports RV32 and RV64 widths.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag (normally the PC) carried alongside each immediate.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous pipeline flush; discards all held entries.
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  stage can accept an instruction this cycle.
- in_instr  input  25  instruction bits [31:7].
- in_imm_src  input  3  immediate type select.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  out_imm/out_tag/out_illegal hold a valid entry.
- out_ready  input  1  downstream accepts the entry.
- out_imm  output  XLEN  extended immediate.
- out_tag  output  TAG_W  tag of the presented entry.
- out_illegal  output  1  in_imm_src was unsupported for the presented entry.

Behaviour:
- Reset is decided: one clock, clk; reset rst_n is asynchronous, active-low.
  - While rst_n is low: out_valid=0, out_imm=0, out_tag=0, out_illegal=0, in_ready=1 (registered), state=EMPTY.
  - Reset mid-operation drops every held entry.
- Handshake:
  - Input transfer occurs when in_valid & in_ready at a rising edge.
  - Output transfer occurs when out_valid & out_ready.
  - out_imm/out_tag/out_illegal stay stable while out_valid & !out_ready.
- Latency: 1 cycle. An entry accepted at edge N is presented from edge N onward if the output register is free.
- Storage: main register (presented) plus skid register.
  - in_ready is registered and equals !skid_valid; it is never combinationally dependent on out_ready.
- State machine (main_valid, skid_valid):
  - EMPTY: accept -> ONE.
  - ONE:
    - accept & !pop -> TWO, incoming entry goes to skid.
    - accept & pop -> ONE, incoming entry goes to main.
    - pop only -> EMPTY.
  - TWO: in_ready=0; pop -> ONE, skid moves to main.
  - Simultaneous accept and pop in ONE keeps ordering; entries always leave in arrival order.
- Flush:
  - At an edge with flush=1: both valids cleared, state -> EMPTY, in_ready=1 next cycle.
  - Flush overrides a same-cycle input transfer (input dropped) and a same-cycle pop.
  - out_imm is not required to clear.
- Extension, computed before the register; sign bit s = instr[31], replicated to XLEN:
  - 000 U: {s.., instr[31:12], 12'b0}. Upper bits are zero for XLEN=32 and sign-extended for XLEN=64.
  - 001 J: {s.., instr[19:12], instr[20], instr[30:21], 1'b0}.
  - 010 S: {s.., instr[31:25], instr[11:7]}.
  - 011 B: {s.., instr[7], instr[30:25], instr[11:8], 1'b0}.
  - 100 I: {s.., instr[31:20]}.
  - 101 shift amount, zero-extended:
    - XLEN=32: instr[24:20].
    - XLEN=64: instr[25:20].
  - 110 I unsigned: zero-extended instr[31:20].
  - 111: see Optional Feature.
- out_illegal is registered alongside the entry; it is 0 for all supported codes.

Optional Feature:
- Macro: IMM_EXT_ZICSR_EN.
- Defined: code 111 is the CSR zimm type. out_imm = zero-extended instr[19:15], out_illegal=0.
- Undefined: code 111 gives out_imm=0 and out_illegal=1. The entry still flows through the handshake normally.

Test Plan:
- Reset release, idle: in_ready=1, out_valid=0, out_imm=0 after rst_n rises.
- Codes 000 / 100 / 011, XLEN=32:
  - instr=0x12345037, src 000 -> out_imm 0x12345000 one cycle later.
  - instr=0xFFF00093, src 100 -> 0xFFFFFFFF.
  - instr=0xFE000EE3, src 011 -> 0xFFFFFFFC.
  - out_tag matches in each case.
- Backpressure:
  - With out_ready=0, offer tags A, B, C back-to-back.
  - Required: A and B accepted, in_ready=0 after B, C held upstream.
  - After out_ready=1: outputs A, B, C in order; no duplicates, no drops.
- Flush in TWO with in_valid=1 same cycle: next cycle out_valid=0, in_ready=1, offered entry absent from output.
- XLEN=64:
  - instr[31:7] with bits 25:20=0x3F, src 101 -> 0x000000000000003F.
  - instr=0x800000B7, src 000 -> 0xFFFFFFFF80000000.
- Code 111, instr[19:15]=0x1F:
  - IMM_EXT_ZICSR_EN defined -> out_imm=0x1F, out_illegal=0.
  - IMM_EXT_ZICSR_EN undefined -> out_imm=0, out_illegal=1.
